// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency: WIDTH+2 cycles from acceptance to done; b==0 and signed overflow take 1 cycle.
// Backpressure: stall holds the result in DONE; start is ignored while busy or stalled.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             div_zero;
    logic             ovf;
    logic             fast;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic             last;

    assign accept   = start && (state == IDLE || (state == DONE && !stall));
    assign div_zero = (b == '0);
    assign ovf      = signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign fast     = div_zero || ovf;
    assign a_mag    = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (signed_op && b[WIDTH-1]) ? -b : b;

    // A non-negative WIDTH+1-bit trial difference is the same as shifted >= divisor.
    assign shifted  = {rem, dvd[WIDTH-1]};
    assign fits     = shifted >= {1'b0, dsr};
    assign diff     = shifted[WIDTH-1:0] - dsr;
    assign last     = (cnt == CW'(WIDTH-1));

    assign busy     = (state == CALC) || (state == FIX);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = fast ? DONE : CALC;
            end
            CALC: begin
                if (last) state_nxt = FIX;
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (!stall) state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            dvd   <= '0;
            rem   <= '0;
            dsr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else if (accept) begin
            cnt   <= '0;
            dvd   <= a_mag;
            rem   <= '0;
            dsr   <= b_mag;
            neg_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= signed_op && a[WIDTH-1];
            if (div_zero) begin
                q <= '1;
                r <= a;
            end else if (ovf) begin
                q <= {1'b1, {(WIDTH-1){1'b0}}};
                r <= '0;
            end
        end else if (state == CALC) begin
            // dvd doubles as the quotient shift register as dividend bits leave it.
            cnt <= cnt + 1'b1;
            if (fits) begin
                rem <= diff;
                dvd <= {dvd[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                dvd <= {dvd[WIDTH-2:0], 1'b0};
            end
        end else if (state == FIX) begin
            q <= neg_q ? -dvd : dvd;
            r <= neg_r ? -rem : rem;
        end
    end

endmodule
